// File: rtl/reaction_timer.sv
// reaction_timer
// Measures the delay between the stimulus lamp lighting and the response button
// press. After a start press it waits WAIT_TICKS ticks, lights the LED, then
// counts ticks in four BCD digits until the response button is pressed.
// A press before the LED lights is flagged early. A count that would pass 9999
// is flagged timeout.
// Optional build macro: DEBOUNCE_EN. When it is defined, each synchronized
// button feeds a DEB_CYCLES stability filter before edge detection.
module reaction_timer #(
    parameter int CLK_HZ     = 100000000,
    parameter int TICK_HZ    = 1000,
    parameter int WAIT_TICKS = 1000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        resp,
    output logic        led,
    output logic        busy,
    output logic        done,
    output logic        early,
    output logic        timeout,
    output logic [15:0] result
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WW  = $clog2(WAIT_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_TICKS - 1);

    // Legal parameter sets: an integer divider of at least 2, a non-empty wait
    // and a non-empty debounce window.
    localparam bit PARAMS_OK = (DIV >= 2) && (WAIT_TICKS >= 1) && (DEB_CYCLES >= 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          state_reg;
    logic [PW-1:0]   presc_reg;
    logic [WW-1:0]   wait_cnt_reg;
    logic [15:0]     bcd_reg;
    logic [15:0]     bcd_inc;
    logic            bcd_all_nines;
    logic            tick;
    logic [1:0]      btn_raw;
    logic [1:0]      btn_evt;
    logic            start_evt;
    logic            resp_evt;

    genvar gi;

    // Empty hook block. It elaborates only for an illegal parameter set, so the
    // bad configuration is visible in the elaborated hierarchy.
    generate
        if (!PARAMS_OK) begin : g_invalid_params
        end
    endgenerate

    // ------------------------------------------------------------------
    // Button conditioning: bit 0 = start, bit 1 = resp.
    // ------------------------------------------------------------------
    assign btn_raw = {resp, start};

    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic meta_reg;
            logic sync_reg;
            logic prev_reg;
            logic level;

            // Two-flop synchronizer for the asynchronous button level.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= btn_raw[gi];
                    sync_reg <= meta_reg;
                end
            end

`ifdef DEBOUNCE_EN
            localparam int DW = $clog2(DEB_CYCLES + 1);
            localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
            logic [DW-1:0] deb_cnt_reg;
            logic          deb_reg;

            // The filtered level follows the synchronized input only after the
            // input has disagreed with it for DEB_CYCLES clocks in a row.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    deb_cnt_reg <= '0;
                    deb_reg     <= 1'b0;
                end else if (sync_reg == deb_reg) begin
                    deb_cnt_reg <= '0;
                end else if (deb_cnt_reg == DEB_LAST) begin
                    deb_cnt_reg <= '0;
                    deb_reg     <= sync_reg;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + 1'b1;
                end
            end

            assign level = deb_reg;
`else
            assign level = sync_reg;
`endif

            // Previous-value flop used for rising-edge detection.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_reg <= 1'b0;
                end else begin
                    prev_reg <= level;
                end
            end

            assign btn_evt[gi] = level & ~prev_reg;
        end
    endgenerate

    assign start_evt = btn_evt[0];
    assign resp_evt  = btn_evt[1];

    // ------------------------------------------------------------------
    // Tick and BCD increment
    // ------------------------------------------------------------------
    assign tick = (presc_reg == PRESC_LAST);

    // Ripple a +1 through the four BCD digits. Each digit wraps 9 to 0 and
    // carries. bcd_all_nines marks the saturation point.
    always_comb begin
        logic       carry;
        logic [3:0] digit;
        carry   = 1'b1;
        digit   = 4'd0;
        bcd_inc = bcd_reg;
        for (int i = 0; i < 4; i++) begin
            digit = bcd_reg[i*4 +: 4];
            if (carry) begin
                bcd_inc[i*4 +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
            end
            carry = carry & (digit == 4'd9);
        end
        bcd_all_nines = carry;
    end

    // ------------------------------------------------------------------
    // Control FSM with prescaler, wait counter, BCD counter and registered
    // outputs. The prescaler restarts on every state entry, so the first tick
    // of any state comes DIV cycles after entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            presc_reg    <= '0;
            wait_cnt_reg <= '0;
            bcd_reg      <= 16'h0000;
            led          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            early        <= 1'b0;
            timeout      <= 1'b0;
            result       <= 16'h0000;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;

            case (state_reg)
                // Idle and done behave the same way: only a start press matters.
                S_IDLE, S_DONE: begin
                    if (start_evt) begin
                        state_reg    <= S_WAIT;
                        presc_reg    <= '0;
                        wait_cnt_reg <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        early        <= 1'b0;
                        timeout      <= 1'b0;
                    end
                end

                S_WAIT: begin
                    if (resp_evt) begin
                        // A response before the lamp wins over a coincident last tick.
                        state_reg <= S_DONE;
                        presc_reg <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        early     <= 1'b1;
                        result    <= 16'h0000;
                    end else if (tick) begin
                        if (wait_cnt_reg == WAIT_LAST) begin
                            state_reg <= S_MEASURE;
                            presc_reg <= '0;
                            bcd_reg   <= 16'h0000;
                            led       <= 1'b1;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 1'b1;
                        end
                    end
                end

                S_MEASURE: begin
                    if (resp_evt) begin
                        // A response in the same cycle as a tick discards that tick.
                        state_reg <= S_DONE;
                        presc_reg <= '0;
                        led       <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= bcd_reg;
                    end else if (tick) begin
                        if (bcd_all_nines) begin
                            state_reg <= S_DONE;
                            presc_reg <= '0;
                            led       <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            timeout   <= 1'b1;
                            result    <= 16'h9999;
                        end else begin
                            bcd_reg <= bcd_inc;
                        end
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
